// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if: requester-side bus of the shared register arbiter
interface shared_reg_arbiter_if #(parameter int NREQ = 4, parameter int WIDTH = 8);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic [OW-1:0]         owner;
    logic                  busy;
    modport master (output req, wdata, input gnt, ack, q, owner, busy);
    modport slave  (input req, wdata, output gnt, ack, q, owner, busy);
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write arbiter owning the only write path of a shared register
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    shared_reg_arbiter_if.slave bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;
    state_t            state, state_n;
    logic [OW-1:0]     ptr, ptr_n, owner, owner_n, win;
    logic [NREQ-1:0]   gnt, gnt_n, ack, ack_n;
    logic [WIDTH-1:0]  q, q_n;
    logic              busy, busy_n;
    int                idx;
    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        win = '0;
        idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (bus.req[idx]) win = OW'(idx);
        end
    end
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        gnt_n   = '0;
        ack_n   = '0;
        q_n     = q;
        busy_n  = 1'b0;
        unique case (state)
            IDLE: if (|bus.req) begin
                owner_n    = win;
                gnt_n[win] = 1'b1;
                busy_n     = 1'b1;
                state_n    = GRANT;
            end
            GRANT: begin
                ptr_n   = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
                state_n = IDLE;
                if (bus.req[owner]) begin
                    q_n          = bus.wdata[owner*WIDTH +: WIDTH];
                    ack_n[owner] = 1'b1;
                    busy_n       = 1'b1;
                    state_n      = COMMIT;
                end
            end
            COMMIT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
            ack   <= '0;
            q     <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            gnt   <= gnt_n;
            ack   <= ack_n;
            q     <= q_n;
            busy  <= busy_n;
        end
    end
    assign bus.gnt   = gnt;
    assign bus.ack   = ack;
    assign bus.q     = q;
    assign bus.owner = owner;
    assign bus.busy  = busy;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_shared_reg_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int OW = $clog2(N);
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q;
    always #5 clk = ~clk;
    shared_reg_arbiter_if #(.NREQ(N), .WIDTH(W)) bus();
    shared_reg_arbiter #(.NREQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Model: a transaction is "waiting", "granted" or "written"; winner chosen by rotating scan.
    int            m_phase;
    int            m_ptr;
    logic [OW-1:0] m_owner;
    logic [W-1:0]  m_q;
    logic [N-1:0]  e_gnt, e_ack;
    logic          e_busy;
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction
    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_ptr   <= 0;
            m_owner <= '0;
            m_q     <= '0;
        end else if (m_phase == 0) begin
            if (|bus.req) begin
                m_owner <= OW'(pick(bus.req, m_ptr));
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_ptr <= (int'(m_owner) + 1) % N;
            if (bus.req[m_owner]) begin
                m_q     <= bus.wdata[m_owner*W +: W];
                m_phase <= 2;
            end else m_phase <= 0;
        end else m_phase <= 0;
    end
    always_comb begin
        e_gnt  = (m_phase == 1) ? (N'(1) << m_owner) : '0;
        e_ack  = (m_phase == 2) ? (N'(1) << m_owner) : '0;
        e_busy = (m_phase != 0);
    end

    task automatic test_reset;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.gnt, bus.ack, bus.q, bus.owner, bus.busy} !== '0) begin
                failures++;
                $display("FAIL reset_state cycle=%0d got gnt=%b ack=%b q=%h owner=%0d busy=%b want all zero",
                         c, bus.gnt, bus.ack, bus.q, bus.owner, bus.busy);
            end
        end
    endtask

    task automatic test_single_write;
        bus.wdata = {W'($urandom), 8'hA5, W'($urandom), W'($urandom)};
        bus.req = 4'b0100;
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.ack, bus.owner, bus.busy} !== {4'b0100, 4'b0000, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL single_grant got gnt=%b ack=%b owner=%0d busy=%b want 0100 0000 2 1", bus.gnt, bus.ack, bus.owner, bus.busy);
        end
        @(negedge clk);
        checks++;
        if ({bus.q, bus.ack, bus.gnt, bus.busy} !== {8'hA5, 4'b0100, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL single_commit got q=%h ack=%b gnt=%b busy=%b want a5 0100 0000 1", bus.q, bus.ack, bus.gnt, bus.busy);
        end
        bus.req = '0;
        exp_q = 8'hA5;
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.ack, bus.busy, bus.owner, bus.q} !== {4'b0, 4'b0, 1'b0, 2'd2, 8'hA5}) begin
            failures++;
            $display("FAIL single_idle got gnt=%b ack=%b busy=%b owner=%0d q=%h want 0 0 0 2 a5", bus.gnt, bus.ack, bus.busy, bus.owner, bus.q);
        end
    endtask

    task automatic test_async_reset;
        bus.req = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL areset_pre_grant got gnt=%b want 0001", bus.gnt);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.ack, bus.q, bus.busy, bus.owner} !== '0) begin
            failures++;
            $display("FAIL areset_immediate got gnt=%b ack=%b q=%h busy=%b owner=%0d want all zero", bus.gnt, bus.ack, bus.q, bus.busy, bus.owner);
        end
        bus.req = '0;
        #1 rst = 1'b1;
        exp_q = '0;
        test_reset();
    endtask

    task automatic test_contention;
        logic [W-1:0] wd [N];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int order [$];
        int last = 0;
        for (int i = 0; i < N; i++) begin
            wd[i] = W'($urandom);
            bus.wdata[i*W +: W] = wd[i];
        end
        bus.req = '1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (|bus.gnt) begin
                checks++;
                if (order.size() >= 5 || idx_of(bus.gnt) != exp_order[order.size() % 5]) begin
                    failures++;
                    $display("FAIL contention_order grant#%0d got=%0d want=%0d", order.size(), idx_of(bus.gnt), exp_order[order.size() % 5]);
                end
                if (order.size() > 0) begin
                    checks++;
                    if (c - last != 3) begin
                        failures++;
                        $display("FAIL contention_spacing got=%0d want=3", c - last);
                    end
                end
                last = c;
                order.push_back(idx_of(bus.gnt));
            end
            if (|bus.ack) begin
                checks++;
                if (bus.q !== wd[idx_of(bus.ack)]) begin
                    failures++;
                    $display("FAIL contention_q got=%h want=%h", bus.q, wd[idx_of(bus.ack)]);
                end
            end
            bus.req = (c == 14) ? '0 : ~bus.ack;
        end
        exp_q = wd[0];
        @(negedge clk);
        checks++;
        if (order.size() != 5 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL contention_count got grants=%0d busy=%b want 5 0", order.size(), bus.busy);
        end
    endtask

    task automatic test_abort;
        bus.wdata = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
        bus.req = 4'b0110;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL abort_grant1 got gnt=%b want 0010", bus.gnt);
        end
        bus.req = 4'b0100;
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.ack, bus.busy, bus.q} !== {4'b0, 4'b0, 1'b0, exp_q}) begin
            failures++;
            $display("FAIL abort_nowrite got gnt=%b ack=%b busy=%b q=%h want 0 0 0 %h", bus.gnt, bus.ack, bus.busy, bus.q, exp_q);
        end
        bus.req = 4'b0110;
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.owner} !== {4'b0100, 2'd2}) begin
            failures++;
            $display("FAIL abort_ptr got gnt=%b owner=%0d want 0100 2", bus.gnt, bus.owner);
        end
        @(negedge clk);
        checks++;
        if ({bus.ack, bus.q} !== {4'b0100, bus.wdata[2*W +: W]}) begin
            failures++;
            $display("FAIL abort_commit2 got ack=%b q=%h want 0100 %h", bus.ack, bus.q, bus.wdata[2*W +: W]);
        end
        exp_q = bus.wdata[2*W +: W];
        bus.req = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        bus.wdata = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
        bus.req = 4'b1000;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_grant3 got gnt=%b want 1000", bus.gnt);
        end
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        bus.req = 4'b1001;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_first got gnt=%b want 0001", bus.gnt);
        end
        @(negedge clk);
        checks++;
        if ({bus.ack, bus.q} !== {4'b0001, bus.wdata[W-1:0]}) begin
            failures++;
            $display("FAIL wrap_commit0 got ack=%b q=%h want 0001 %h", bus.ack, bus.q, bus.wdata[W-1:0]);
        end
        bus.req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_second got gnt=%b want 1000", bus.gnt);
        end
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
    endtask

    task automatic test_rerequest;
        int exp_order [3] = '{0, 1, 0};
        int order [$];
        int writes0 = 0;
        bus.wdata = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
        bus.req = 4'b0011;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (|bus.gnt) begin
                checks++;
                if (order.size() >= 3 || idx_of(bus.gnt) != exp_order[order.size() % 3]) begin
                    failures++;
                    $display("FAIL rereq_order grant#%0d got=%0d want=%0d", order.size(), idx_of(bus.gnt), exp_order[order.size() % 3]);
                end
                order.push_back(idx_of(bus.gnt));
            end
            if (bus.ack[0]) begin
                writes0++;
                checks++;
                if (bus.q !== bus.wdata[W-1:0]) begin
                    failures++;
                    $display("FAIL rereq_q0 got=%h want=%h", bus.q, bus.wdata[W-1:0]);
                end
                if (writes0 == 2) bus.req[0] = 1'b0;
            end
            if (bus.ack[1]) bus.req[1] = 1'b0;
        end
        checks++;
        if (order.size() != 3 || writes0 != 2 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rereq_totals got grants=%0d writes0=%0d busy=%b want 3 2 0", order.size(), writes0, bus.busy);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] r;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.gnt, bus.ack, bus.q, bus.owner, bus.busy} !== {e_gnt, e_ack, m_q, m_owner, e_busy}) begin
                failures++;
                $display("FAIL random cycle=%0d got gnt=%b ack=%b q=%h owner=%0d busy=%b want %b %b %h %0d %b",
                         c, bus.gnt, bus.ack, bus.q, bus.owner, bus.busy, e_gnt, e_ack, m_q, m_owner, e_busy);
            end
            r = bus.req;
            for (int i = 0; i < N; i++) begin
                if (r[i] && bus.ack[i]) r[i] = 1'b0;
                else if (r[i] && bus.gnt[i] && $urandom_range(7) == 0) r[i] = 1'b0;
                else if (!r[i] && $urandom_range(2) == 0) begin
                    r[i] = 1'b1;
                    bus.wdata[i*W +: W] = W'($urandom);
                end
            end
            bus.req = (c >= 395) ? '0 : r;
        end
    endtask

    initial begin
        bus.req = '0;
        bus.wdata = '0;
        exp_q = '0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_single_write();
        test_async_reset();
        test_contention();
        test_abort();
        test_wrap();
        test_rerequest();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
